riscv_insn_decode: RTL and testbench

- Decode/register-read stage directly upstream of the execution unit.
- Accepts 32-bit instructions from fetch over a valid/ready handshake and splits them into fields.
- Reads rs1/rs2 from an internal 32 x XLEN register file and presents a registered bundle to execute.
- Accepts execute's writeback; a per-register busy scoreboard stalls read-after-write hazards.

---
 rtl/riscv_insn_decode_if.sv | 35 +++
 rtl/riscv_insn_decode.sv | 128 ++++++++++++
 tb/tb_riscv_insn_decode.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_insn_decode_if.sv
// Fetch-to-decode, decode-to-execute and writeback signals of the decode stage.
// The slave modport is the decode stage's view. The master modport is the
// surrounding pipeline's view, covering both fetch and execute.
interface riscv_insn_decode_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [19:0]     imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd_addr;
  logic            illegal;
  logic            wb_valid;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport slave (
    input  in_valid, in_insn, out_ready, wb_valid, wb_addr, wb_data,
    output in_ready, out_valid, opcode, funct3, funct7, imm, rs1, rs2,
           rd_addr, illegal
  );

  modport master (
    output in_valid, in_insn, out_ready, wb_valid, wb_addr, wb_data,
    input  in_ready, out_valid, opcode, funct3, funct7, imm, rs1, rs2,
           rd_addr, illegal
  );
endinterface

// File: rtl/riscv_insn_decode.sv
// Decode / register-read stage. It splits the instruction fields, reads rs1
// and rs2 from a 32-entry register file with writeback bypass, and tracks
// pending destination registers in a busy scoreboard so that read-after-write
// hazards stall at the input.
module riscv_insn_decode #(
  parameter int unsigned XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_insn_decode_if.slave   bus
);

  typedef enum logic [6:0] {
    OPC_LUI = 7'b0110111,
    OPC_OP  = 7'b0110011
  } opcode_e;

  logic [XLEN-1:0] regs [32];
  logic [31:0]     busy;

  logic [6:0]      insn_opcode;
  logic [4:0]      src1_idx;
  logic [4:0]      src2_idx;
  logic [4:0]      dst_idx;
  logic            src1_stall;
  logic            src2_stall;
  logic            slot_free;
  logic            ready_int;
  logic            accept;
  logic            is_writer;
  logic            insn_illegal;
  logic [XLEN-1:0] src1_val;
  logic [XLEN-1:0] src2_val;

  // Field extraction, hazard check against the scoreboard, and operand read with bypass.
  always_comb begin
    insn_opcode  = bus.in_insn[6:0];
    src1_idx     = bus.in_insn[19:15];
    src2_idx     = bus.in_insn[24:20];
    dst_idx      = bus.in_insn[11:7];

    // A busy source is released in the same cycle its writeback arrives.
    src1_stall   = (src1_idx != '0) && busy[src1_idx] &&
                   !(bus.wb_valid && (bus.wb_addr == src1_idx));
    src2_stall   = (src2_idx != '0) && busy[src2_idx] &&
                   !(bus.wb_valid && (bus.wb_addr == src2_idx));

    slot_free    = !bus.out_valid || bus.out_ready;
    ready_int    = slot_free && !src1_stall && !src2_stall;
    accept       = bus.in_valid && ready_int;

    is_writer    = (insn_opcode == OPC_LUI) || (insn_opcode == OPC_OP);
    insn_illegal = !is_writer;

    if (src1_idx == '0) begin
      src1_val = '0;
    end else if (bus.wb_valid && (bus.wb_addr == src1_idx)) begin
      src1_val = bus.wb_data;
    end else begin
      src1_val = regs[src1_idx];
    end

    if (src2_idx == '0) begin
      src2_val = '0;
    end else if (bus.wb_valid && (bus.wb_addr == src2_idx)) begin
      src2_val = bus.wb_data;
    end else begin
      src2_val = regs[src2_idx];
    end
  end

  assign bus.in_ready = ready_int;

  // Register file write port. x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_valid && (bus.wb_addr != '0)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Busy scoreboard update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (bus.wb_valid && (bus.wb_addr != '0)) begin
        busy[bus.wb_addr] <= 1'b0;
      end
      // This set comes after the clear, so a newly accepted writer to the same
      // register keeps it busy.
      if (accept && is_writer && (dst_idx != '0)) begin
        busy[dst_idx] <= 1'b1;
      end
    end
  end

  // Output bundle register toward execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.opcode    <= '0;
      bus.funct3    <= '0;
      bus.funct7    <= '0;
      bus.imm       <= '0;
      bus.rs1       <= '0;
      bus.rs2       <= '0;
      bus.rd_addr   <= '0;
      bus.illegal   <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.opcode    <= insn_opcode;
      bus.funct3    <= bus.in_insn[14:12];
      bus.funct7    <= bus.in_insn[31:25];
      bus.imm       <= bus.in_insn[31:12];
      bus.rs1       <= src1_val;
      bus.rs2       <= src2_val;
      bus.rd_addr   <= dst_idx;
      bus.illegal   <= insn_illegal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_insn_decode.sv
// Directed bench for riscv_insn_decode with a cycle-level reference model.
module tb_riscv_insn_decode;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_insn_decode_if #(.XLEN(XLEN)) bus ();
  riscv_insn_decode #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [32];
  bit              m_busy [32];
  bit              e_valid;
  bit              e_illegal;
  logic [6:0]      e_opcode;
  logic [2:0]      e_funct3;
  logic [6:0]      e_funct7;
  logic [19:0]     e_imm;
  logic [XLEN-1:0] e_rs1;
  logic [XLEN-1:0] e_rs2;
  logic [4:0]      e_rd;

  function automatic int fld(input logic [31:0] w, input int lsb, input int width);
    return int'((w >> lsb) & ((32'd1 << width) - 32'd1));
  endfunction

  function automatic bit m_blocked(input int idx);
    return (idx != 0) && m_busy[idx] && !(bus.wb_valid && int'(bus.wb_addr) == idx);
  endfunction

  function automatic bit m_ready();
    return (!e_valid || bus.out_ready) &&
           !m_blocked(fld(bus.in_insn, 15, 5)) && !m_blocked(fld(bus.in_insn, 20, 5));
  endfunction

  function automatic logic [XLEN-1:0] m_read(input int idx);
    if (idx == 0) return '0;
    if (bus.wb_valid && int'(bus.wb_addr) == idx) return bus.wb_data;
    return m_regs[idx];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      e_valid = 0; e_illegal = 0; e_opcode = '0; e_funct3 = '0; e_funct7 = '0;
      e_imm = '0; e_rs1 = '0; e_rs2 = '0; e_rd = '0;
    end else begin
      bit acc;
      logic [XLEN-1:0] v1, v2;
      int op, rd;
      acc = bus.in_valid && m_ready();
      v1  = m_read(fld(bus.in_insn, 15, 5));
      v2  = m_read(fld(bus.in_insn, 20, 5));
      op  = fld(bus.in_insn, 0, 7);
      rd  = fld(bus.in_insn, 7, 5);
      if (bus.wb_valid && bus.wb_addr != 0) begin
        m_regs[bus.wb_addr] = bus.wb_data;
        m_busy[bus.wb_addr] = 1'b0;
      end
      if (acc) begin
        e_valid   = 1;
        e_opcode  = 7'(op);
        e_funct3  = 3'(fld(bus.in_insn, 12, 3));
        e_funct7  = 7'(fld(bus.in_insn, 25, 7));
        e_imm     = 20'(fld(bus.in_insn, 12, 20));
        e_rs1     = v1;
        e_rs2     = v2;
        e_rd      = 5'(rd);
        e_illegal = !(op == 55 || op == 51);
        if (!e_illegal && rd != 0) m_busy[rd] = 1'b1;
      end else if (bus.out_ready) begin
        e_valid = 0;
      end
    end
  end

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready",  bus.in_ready,  m_ready());
      chk("out_valid", bus.out_valid, e_valid);
      chk("opcode",    bus.opcode,    e_opcode);
      chk("funct3",    bus.funct3,    e_funct3);
      chk("funct7",    bus.funct7,    e_funct7);
      chk("imm",       bus.imm,       e_imm);
      chk("rs1",       bus.rs1,       e_rs1);
      chk("rs2",       bus.rs2,       e_rs2);
      chk("rd_addr",   bus.rd_addr,   e_rd);
      chk("illegal",   bus.illegal,   e_illegal);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b0;
  endtask

  task automatic present(input logic [31:0] insn);
    bus.in_valid = 1'b1;
    bus.in_insn  = insn;
  endtask

  task automatic put_wb(input int a, input logic [XLEN-1:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'(a);
    bus.wb_data  = d;
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input int r2, input int r1, input int rd);
    return {f7, 5'(r2), 5'(r1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.in_insn = '0; bus.out_ready = 1;
    bus.wb_valid = 0; bus.wb_addr = '0; bus.wb_data = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);

    // LUI x1, 0x12345 sets busy[1]; a reader of x1 waits for its writeback.
    present(32'h123450B7);
    step();
    idle();
    chk("lui_opcode", bus.opcode, 7'b0110111);
    chk("lui_imm", bus.imm, 20'h12345);
    chk("lui_rd", bus.rd_addr, 1);
    chk("lui_illegal", bus.illegal, 0);
    present(rtype(7'd0, 0, 1, 0));
    #1 chk("raw_stall", bus.in_ready, 0);
    step(); step();
    chk("raw_stall2", bus.in_ready, 0);
    put_wb(1, 32'h12345000);
    #1 chk("raw_release", bus.in_ready, 1);
    step();
    idle();
    chk("raw_rs1", bus.rs1, 32'h12345000);

    // Bypass: x2=5, x3=7; add x4,x2,x3; sub x5,x4,x2 with x4 landing that cycle.
    put_wb(2, 5); step();
    put_wb(3, 7); step();
    idle();
    present(rtype(7'd0, 3, 2, 4));
    step();
    idle();
    chk("add_rs1", bus.rs1, 5);
    chk("add_rs2", bus.rs2, 7);
    present(rtype(7'b0100000, 2, 4, 5));
    put_wb(4, 12);
    #1 chk("byp_ready", bus.in_ready, 1);
    step();
    idle();
    chk("sub_rs1", bus.rs1, 12);
    chk("sub_rs2", bus.rs2, 5);
    chk("sub_funct7", bus.funct7, 7'b0100000);
    put_wb(5, 99); step();
    idle();

    // Backpressure.
    bus.out_ready = 0;
    present(rtype(7'd0, 3, 2, 7));
    step();
    present(rtype(7'd0, 2, 3, 8));
    #1 chk("bp_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_rd", bus.rd_addr, 7);
      chk("bp_hold_rs1", bus.rs1, 5);
      chk("bp_hold_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1;
    #1 chk("bp_release", bus.in_ready, 1);
    step();
    idle();
    chk("bp_next_rd", bus.rd_addr, 8);
    chk("bp_next_rs1", bus.rs1, 7);
    chk("bp_next_rs2", bus.rs2, 5);
    step();
    chk("bp_drain", bus.out_valid, 0);

    // x0 is hardwired to zero and never marked busy.
    put_wb(0, 32'hFFFFFFFF); step();
    idle();
    present(rtype(7'd0, 2, 0, 0));
    step();
    idle();
    chk("x0_rs1", bus.rs1, 0);
    chk("x0_rs2", bus.rs2, 5);
    present(rtype(7'd0, 0, 0, 0));
    #1 chk("x0_no_stall", bus.in_ready, 1);
    step();
    idle();

    // Illegal opcodes pass through and never mark a destination busy.
    present(32'h00000013);
    step();
    idle();
    chk("ill_flag", bus.illegal, 1);
    chk("ill_valid", bus.out_valid, 1);
    chk("ill_opcode", bus.opcode, 7'h13);
    step();
    chk("ill_one_cycle", bus.out_valid, 0);
    present(32'h00000513);
    step();
    present(rtype(7'd0, 0, 10, 0));
    #1 chk("ill_no_busy", bus.in_ready, 1);
    step();
    idle();

    // A new writer to x11 wins over a same-cycle writeback clearing x11.
    present(rtype(7'd0, 0, 0, 11));
    put_wb(11, 3);
    step();
    idle();
    present(rtype(7'd0, 0, 11, 0));
    #1 chk("setwin_stall", bus.in_ready, 0);
    step();
    chk("setwin_stall2", bus.in_ready, 0);
    put_wb(11, 44);
    #1 chk("setwin_release", bus.in_ready, 1);
    step();
    idle();
    chk("setwin_rs1", bus.rs1, 44);

    // Reset mid-operation.
    present(32'h00000637);
    step();
    idle();
    chk("pre_rst_valid", bus.out_valid, 1);
    #1 rst = 1'b1;
    #1 chk("rst_async_valid", bus.out_valid, 0);
    chk("rst_async_rd", bus.rd_addr, 0);
    step();
    rst = 1'b0;
    present(rtype(7'd0, 0, 5, 0));
    #1 chk("post_rst_ready", bus.in_ready, 1);
    step();
    idle();
    chk("post_rst_x5", bus.rs1, 0);
    present(rtype(7'd0, 0, 12, 0));
    #1 chk("post_rst_busy", bus.in_ready, 1);
    step();
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
